// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier: one n-bit add per cycle, 2n-bit product
// after n RUN cycles, with a start/busy/done handshake for execute-stage stalls.
module shift_add_multiplier #(
   parameter int n = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [n-1:0]   a,
   input  logic [n-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*n-1:0] product
);
   localparam int CW = $clog2(n) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [n-1:0]  m;
   logic [n-1:0]  hi;
   logic [n-1:0]  lo;
   logic [CW-1:0] count;
   logic [n:0]    sum;

   // Carry-out lands in sum[n] and becomes hi[n-1] after the shift.
   assign sum = {1'b0, hi} + {1'b0, (lo[0] ? m : {n{1'b0}})};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         m       <= '0;
         hi      <= '0;
         lo      <= '0;
         count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  m     <= a;
                  hi    <= '0;
                  lo    <= b;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               {hi, lo} <= {sum, lo[n-1:1]};
               count    <= count + 1'b1;
               if (count == CW'(n - 1)) begin
                  product <= {sum, lo[n-1:1]};
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               // start is deliberately ignored here; requester re-asserts in IDLE
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
